// File: rtl/ysyx_23060184_ifu_fetch.sv
// ysyx_23060184_ifu_fetch
//   Instruction-fetch read master in front of the SRAM slave. It takes a PC
//   from the next-PC logic and issues one single-beat AXI-lite read on AR/R.
//   The returned word is handed to decode over a valid/ready handshake.
//   Only one transaction is outstanding at a time. Write channels are not
//   driven here.
//
//   Ports
//     clk, resetn        clock (rising edge), asynchronous active-low reset
//     pc, pc_valid       fetch request from next-PC logic
//     pc_ready           high in IDLE only
//     araddr, arvalid    AR channel to SRAM
//     arready            AR channel from SRAM
//     rdata, rresp,      R channel from SRAM (rresp 0 = OKAY)
//     rvalid
//     rready             R channel to SRAM
//     inst, inst_pc      fetched word and its PC
//     inst_valid         to decode
//     inst_ready         from decode
//     fetch_err          qualifies inst_valid: misaligned PC, bad rresp or timeout
//
//   Optional: define YSYX_IFU_TIMEOUT_EN to abandon a fetch that spends
//   TIMEOUT_CYCLES cycles in ADDR/DATA. The abandoned fetch is reported as an
//   error with inst=0.
module ysyx_23060184_ifu_fetch #(
  parameter int DATA_WIDTH     = 32,
  parameter int ACERR_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATA_WIDTH-1:0]  pc,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  output logic [DATA_WIDTH-1:0]  araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic [ACERR_WIDTH-1:0] rresp,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [DATA_WIDTH-1:0]  inst,
  output logic [DATA_WIDTH-1:0]  inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic                   fetch_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t state;

  assign pc_ready = (state == IDLE);

`ifdef YSYX_IFU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  // Cleared while idle, so it starts from zero on entry to ADDR. It counts
  // every cycle spent in ADDR or DATA. The last counted cycle triggers
  // the abort, so inst_valid appears TIMEOUT_CYCLES cycles after ADDR entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else begin
      case (state)
        IDLE:       to_cnt <= '0;
        ADDR, DATA: to_cnt <= to_cnt + 1'b1;
        default:    to_cnt <= to_cnt;
      endcase
    end
  end

  assign to_hit = (to_cnt >= TO_LAST);
`else
  // Without the timeout feature the block waits in ADDR/DATA indefinitely
  // and TIMEOUT_CYCLES has no effect.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_inert
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      araddr     <= '0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_valid) begin
            araddr  <= pc;
            inst_pc <= pc;
            if (pc[1:0] != 2'b00) begin
              // Misaligned: report the error directly, no bus access.
              inst       <= '0;
              fetch_err  <= 1'b1;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              arvalid <= 1'b1;
              state   <= ADDR;
            end
          end
        end

        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
`ifdef YSYX_IFU_TIMEOUT_EN
          else if (to_hit) begin
            inst       <= '0;
            fetch_err  <= 1'b1;
            inst_valid <= 1'b1;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            state      <= HOLD;
          end
`endif
        end

        DATA: begin
          if (rvalid) begin
            inst       <= rdata;
            fetch_err  <= (rresp != '0);
            inst_valid <= 1'b1;
            rready     <= 1'b0;
            state      <= HOLD;
          end
`ifdef YSYX_IFU_TIMEOUT_EN
          else if (to_hit) begin
            inst       <= '0;
            fetch_err  <= 1'b1;
            inst_valid <= 1'b1;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            state      <= HOLD;
          end
`endif
        end

        HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_ifu_fetch.sv
module tb_ysyx_23060184_ifu_fetch;

  logic        clk;
  logic        resetn;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;

  ysyx_23060184_ifu_fetch #(
    .DATA_WIDTH    (32),
    .ACERR_WIDTH   (2),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pcv;
    logic        arr;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        ir;
    logic        e_pcr;
    logic        e_arv;
    logic [31:0] e_ara;
    logic        e_rdy;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   hs_cnt   = 0;

  always @(posedge clk) begin
    if (resetn && arvalid && arready) hs_cnt++;
  end

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%08h required=0x%08h", name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic pv, input logic [31:0] pcv, input logic arr, input logic rv,
                     input logic [31:0] rd, input logic [1:0] rr, input logic ir,
                     input logic e_pcr, input logic e_arv, input logic [31:0] e_ara,
                     input logic e_rdy, input logic e_iv, input logic [31:0] e_inst,
                     input logic [31:0] e_ipc, input logic e_err);
    vec_t v;
    v.pv = pv; v.pcv = pcv; v.arr = arr; v.rv = rv; v.rd = rd; v.rr = rr; v.ir = ir;
    v.e_pcr = e_pcr; v.e_arv = e_arv; v.e_ara = e_ara; v.e_rdy = e_rdy;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog row=0 actual=0x00000001 required=0x00000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    resetn = 1'b0; pc = '0; pc_valid = 1'b0; arready = 1'b0;
    rdata = '0; rresp = '0; rvalid = 1'b0; inst_ready = 1'b0;

    // Per-cycle vectors: inputs applied for the cycle, expected outputs seen in it.
    // Nominal fetch: accept, AR, R, inst_valid three cycles after accept.
    add(1, 32'h80000000, 1, 1, 32'h00000413, 0, 0,  1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 32'h80000000, 1, 1, 32'h00000413, 0, 0,  0, 1, 32'h80000000, 0, 0, 32'h0,        32'h80000000, 0);
    add(1, 32'h80000000, 1, 1, 32'h00000413, 0, 0,  0, 0, 32'h80000000, 1, 0, 32'h0,        32'h80000000, 0);
    // Back-pressure from decode: 4 cycles with inst_ready=0 and a pending pc.
    for (int i = 0; i < 4; i++)
      add(1, 32'h80000004, 0, 0, 32'h0, 0, 0,       0, 0, 32'h80000000, 0, 1, 32'h00000413, 32'h80000000, 0);
    add(1, 32'h80000004, 0, 0, 32'h0, 0, 1,         0, 0, 32'h80000000, 0, 1, 32'h00000413, 32'h80000000, 0);
    add(1, 32'h80000004, 0, 0, 32'h0, 0, 0,         1, 0, 32'h80000000, 0, 0, 32'h00000413, 32'h80000000, 0);
    // arready low for 5 cycles; a stray rvalid in ADDR must be ignored.
    for (int i = 0; i < 5; i++)
      add(0, 32'h0, 0, 1, 32'h12345678, 0, 0,       0, 1, 32'h80000004, 0, 0, 32'h00000413, 32'h80000004, 0);
    add(0, 32'h0, 1, 0, 32'h0, 0, 0,                0, 1, 32'h80000004, 0, 0, 32'h00000413, 32'h80000004, 0);
    // Error response still delivers the data.
    add(0, 32'h0, 0, 1, 32'hDEADBEEF, 2, 0,         0, 0, 32'h80000004, 1, 0, 32'h00000413, 32'h80000004, 0);
    add(0, 32'h0, 0, 0, 32'h0, 0, 1,                0, 0, 32'h80000004, 0, 1, 32'hDEADBEEF, 32'h80000004, 1);
    // Misaligned pc: error one cycle after accept, no AR.
    add(1, 32'h80000002, 0, 0, 32'h0, 0, 0,         1, 0, 32'h80000004, 0, 0, 32'hDEADBEEF, 32'h80000004, 0);
    add(0, 32'h0, 0, 0, 32'h0, 0, 1,                0, 0, 32'h80000002, 0, 1, 32'h0,        32'h80000002, 1);
    add(0, 32'h0, 0, 0, 32'h0, 0, 0,                1, 0, 32'h80000002, 0, 0, 32'h0,        32'h80000002, 0);

    tick();
    chk("rst_pc_ready",   0, {31'b0, pc_ready},   32'h1);
    chk("rst_arvalid",    0, {31'b0, arvalid},    32'h0);
    chk("rst_rready",     0, {31'b0, rready},     32'h0);
    chk("rst_inst_valid", 0, {31'b0, inst_valid}, 32'h0);
    chk("rst_fetch_err",  0, {31'b0, fetch_err},  32'h0);
    chk("rst_inst",       0, inst,                32'h0);
    tick();
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      pc_valid = vecs[i].pv; pc = vecs[i].pcv; arready = vecs[i].arr; rvalid = vecs[i].rv;
      rdata = vecs[i].rd; rresp = vecs[i].rr; inst_ready = vecs[i].ir;
      #1;
      chk("pc_ready",   i, {31'b0, pc_ready},   {31'b0, vecs[i].e_pcr});
      chk("arvalid",    i, {31'b0, arvalid},    {31'b0, vecs[i].e_arv});
      chk("araddr",     i, araddr,              vecs[i].e_ara);
      chk("rready",     i, {31'b0, rready},     {31'b0, vecs[i].e_rdy});
      chk("inst_valid", i, {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
      chk("inst",       i, inst,                vecs[i].e_inst);
      chk("inst_pc",    i, inst_pc,             vecs[i].e_ipc);
      chk("fetch_err",  i, {31'b0, fetch_err},  {31'b0, vecs[i].e_err});
      tick();
    end
    chk("ar_handshakes", 0, hs_cnt, 32'd2);

    // Asynchronous reset while waiting in DATA, then a late R beat.
    pc_valid = 1'b1; pc = 32'h80000008; arready = 1'b1; rvalid = 1'b0; inst_ready = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    chk("mid_rready_before", 0, {31'b0, rready}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("async_arvalid",    0, {31'b0, arvalid},    32'h0);
    chk("async_rready",     0, {31'b0, rready},     32'h0);
    chk("async_inst_valid", 0, {31'b0, inst_valid}, 32'h0);
    chk("async_pc_ready",   0, {31'b0, pc_ready},   32'h1);
    tick();
    resetn = 1'b1;
    rvalid = 1'b1; rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_r_inst_valid", i, {31'b0, inst_valid}, 32'h0);
      chk("late_r_rready",     i, {31'b0, rready},     32'h0);
    end
    rvalid = 1'b0;

    // R never arrives.
    pc_valid = 1'b1; pc = 32'h8000000C; arready = 1'b1; inst_ready = 1'b0;
    tick();
    pc_valid = 1'b0;
    chk("to_arvalid", 0, {31'b0, arvalid}, 32'h1);
`ifdef YSYX_IFU_TIMEOUT_EN
    k = 0;
    while (!inst_valid && k < 50) begin
      tick();
      k++;
    end
    chk("to_latency",  0, k,                     32'd10);
    chk("to_err",      0, {31'b0, fetch_err},    32'h1);
    chk("to_inst",     0, inst,                  32'h0);
    chk("to_rready",   0, {31'b0, rready},       32'h0);
    chk("to_arvalid0", 0, {31'b0, arvalid},      32'h0);
    inst_ready = 1'b1;
    tick();
    chk("to_back_idle", 0, {31'b0, pc_ready},    32'h1);
`else
    k = 0;
    repeat (1000) begin
      tick();
      k++;
    end
    chk("wait_rready",     k, {31'b0, rready},     32'h1);
    chk("wait_inst_valid", k, {31'b0, inst_valid}, 32'h0);
    chk("wait_pc_ready",   k, {31'b0, pc_ready},   32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
